// File: rtl/ap_ctrl_txn_driver.sv
// ap_ctrl_txn_driver
//   Initiator for the ap_ctrl_chain block-level handshake. Launches a batch of
//   kernel runs by driving ap_start/ap_continue and consuming ap_ready/ap_done.
//   It timestamps each issue and completion and streams per-run latency records
//   out on a valid/ready interface. finish_o pulses once when the batch has
//   retired and every record has been consumed.
//
// Ports
//   clock_i, reset_i       rising-edge clock, asynchronous active-high reset
//   cfg_start_i            1-cycle batch request, sampled only in idle
//   cfg_num_txn_i          number of runs in the batch, sampled with cfg_start_i
//   busy_o                 batch in progress (issuing or draining)
//   finish_o               1-cycle pulse: batch complete, result FIFO empty
//   err_o                  sticky: ap_done accepted with no run in flight
//   ap_start_o/ap_ready_i  issue handshake to the kernel
//   ap_done_i/ap_continue_o completion handshake from the kernel
//   res_valid_o/res_ready_i result stream handshake (FWFT FIFO output)
//   res_index_o            0-based run number in issue order
//   res_latency_o          cycles from issue handshake to done handshake
module ap_ctrl_txn_driver #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned IDX_W    = 16,
  parameter int unsigned IQ_DEPTH = 4,
  parameter int unsigned RQ_DEPTH = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             cfg_start_i,
  input  logic [IDX_W-1:0] cfg_num_txn_i,
  output logic             busy_o,
  output logic             finish_o,
  output logic             err_o,
  output logic             ap_start_o,
  input  logic             ap_ready_i,
  input  logic             ap_done_i,
  output logic             ap_continue_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [IDX_W-1:0] res_index_o,
  output logic [CNT_W-1:0] res_latency_o
);

  localparam int unsigned IqAw = $clog2(IQ_DEPTH);
  localparam int unsigned RqAw = $clog2(RQ_DEPTH);
  localparam logic [IqAw:0] IqFull = (IqAw+1)'(IQ_DEPTH);
  localparam logic [RqAw:0] RqFull = (RqAw+1)'(RQ_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] num_q, issued_q, retired_q;
  logic [CNT_W-1:0] cyc_q;
  logic             err_q;

  // Issue-timestamp queue: one entry per run in flight.
  logic [CNT_W-1:0] iq_mem_q [IQ_DEPTH];
  logic [IqAw-1:0]  iq_wptr_q, iq_rptr_q;
  logic [IqAw:0]    iq_cnt_q;

  // Result FIFO.
  logic [IDX_W-1:0] rq_idx_q [RQ_DEPTH];
  logic [CNT_W-1:0] rq_lat_q [RQ_DEPTH];
  logic [RqAw-1:0]  rq_wptr_q, rq_rptr_q;
  logic [RqAw:0]    rq_cnt_q;

  logic             active;
  logic             iq_empty, iq_full, rq_empty, rq_full;
  logic             issue_hs, done_hs, done_ok, done_err;
  logic             iq_push, iq_pop, rq_push, rq_pop;
  logic [CNT_W-1:0] head_ts;

  always_comb begin
    active   = (state_q == StRun) || (state_q == StDrain);
    iq_empty = (iq_cnt_q == '0);
    iq_full  = (iq_cnt_q == IqFull);
    rq_empty = (rq_cnt_q == '0);
    rq_full  = (rq_cnt_q == RqFull);

    // Both handshake enables come from registers only.
    ap_start_o    = (state_q == StRun) && (issued_q < num_q) && !iq_full;
    ap_continue_o = active && !rq_full;

    issue_hs = ap_start_o && ap_ready_i;
    done_hs  = ap_done_i && ap_continue_o;
    // A done that coincides with the first issue into an empty queue retires
    // that same run with latency 0; only a done with nothing in flight at all
    // is an error.
    done_ok  = done_hs && (!iq_empty || issue_hs);
    done_err = done_hs && iq_empty && !issue_hs;
    head_ts  = iq_empty ? cyc_q : iq_mem_q[iq_rptr_q];

    iq_push = issue_hs && !(done_ok && iq_empty);
    iq_pop  = done_ok && !iq_empty;
    rq_push = done_ok;
    rq_pop  = !rq_empty && res_ready_i;

    busy_o        = active;
    finish_o      = (state_q == StDone);
    err_o         = err_q;
    res_valid_o   = !rq_empty;
    res_index_o   = rq_empty ? '0 : rq_idx_q[rq_rptr_q];
    res_latency_o = rq_empty ? '0 : rq_lat_q[rq_rptr_q];
  end

  // Storage arrays carry no reset; occupancy counters qualify their contents.
  always_ff @(posedge clock_i) begin
    if (iq_push) iq_mem_q[iq_wptr_q] <= cyc_q;
    if (rq_push) begin
      rq_idx_q[rq_wptr_q] <= retired_q;
      rq_lat_q[rq_wptr_q] <= cyc_q - head_ts;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      num_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      cyc_q     <= '0;
      err_q     <= 1'b0;
      iq_wptr_q <= '0;
      iq_rptr_q <= '0;
      iq_cnt_q  <= '0;
      rq_wptr_q <= '0;
      rq_rptr_q <= '0;
      rq_cnt_q  <= '0;
    end else begin
      if (active) cyc_q <= cyc_q + CNT_W'(1);
      if (issue_hs) issued_q <= issued_q + IDX_W'(1);
      if (done_ok) retired_q <= retired_q + IDX_W'(1);
      if (done_err) err_q <= 1'b1;

      if (iq_push) iq_wptr_q <= iq_wptr_q + IqAw'(1);
      if (iq_pop) iq_rptr_q <= iq_rptr_q + IqAw'(1);
      iq_cnt_q <= iq_cnt_q + (IqAw+1)'(iq_push) - (IqAw+1)'(iq_pop);

      if (rq_push) rq_wptr_q <= rq_wptr_q + RqAw'(1);
      if (rq_pop) rq_rptr_q <= rq_rptr_q + RqAw'(1);
      rq_cnt_q <= rq_cnt_q + (RqAw+1)'(rq_push) - (RqAw+1)'(rq_pop);

      unique case (state_q)
        StIdle: begin
          if (cfg_start_i) begin
            issued_q  <= '0;
            retired_q <= '0;
            cyc_q     <= '0;
            if (cfg_num_txn_i != '0) begin
              num_q   <= cfg_num_txn_i;
              state_q <= StRun;
            end else begin
              // Empty batch: report completion straight away.
              state_q <= StDone;
            end
          end
        end
        StRun: begin
          if (issued_q == num_q) state_q <= StDrain;
        end
        StDrain: begin
          if ((retired_q == num_q) && rq_empty) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_ctrl_txn_driver.sv
module tb_ap_ctrl_txn_driver;

  localparam int IqDepth = 4;
  localparam int RqDepth = 4;

  typedef struct {
    int        idx;
    bit [31:0] lat;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_num = '0;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        res_ready = 1'b0;
  logic        busy, finish, err, ap_start, ap_continue, res_valid;
  logic [15:0] res_index;
  logic [31:0] res_latency;

  always #5 clock = ~clock;

  ap_ctrl_txn_driver #(
    .CNT_W   (32),
    .IDX_W   (16),
    .IQ_DEPTH(IqDepth),
    .RQ_DEPTH(RqDepth)
  ) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .cfg_start_i  (cfg_start),
    .cfg_num_txn_i(cfg_num),
    .busy_o       (busy),
    .finish_o     (finish),
    .err_o        (err),
    .ap_start_o   (ap_start),
    .ap_ready_i   (ap_ready),
    .ap_done_i    (ap_done),
    .ap_continue_o(ap_continue),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_index_o  (res_index),
    .res_latency_o(res_latency)
  );

  int cmp_cnt = 0;
  int mis_cnt = 0;

  // Reference model: batch bookkeeping in terms of runs, timestamps and records.
  bit        m_active, m_finish, m_err;
  int        m_n, m_issued, m_retired;
  bit [31:0] m_cyc;
  bit [31:0] m_iq[$];
  rec_t      m_rq[$];

  // Kernel / consumer environment.
  int now = 0;
  int k_due[$];
  int ready_pct, done_pct, rr_pct, dly_min, dly_max;
  bit frc, f_ready, f_done;
  int        rx_idx[$];
  bit [31:0] rx_lat[$];
  int fin_cnt = 0;
  int iss_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_finish = 0; m_err = 0;
    m_n = 0; m_issued = 0; m_retired = 0; m_cyc = 0;
    m_iq.delete();
    m_rq.delete();
  endtask

  task automatic cycle();
    bit        e_start, e_cont, e_valid, act_pre, idle_pre, exit_now;
    int        rq_pre, ret_pre, last, d;
    bit [31:0] t;
    if (frc) begin
      ap_ready = f_ready;
      ap_done  = f_done;
    end else begin
      ap_ready = ($urandom_range(99) < ready_pct);
      ap_done  = (k_due.size() > 0) && (k_due[0] <= now) && ($urandom_range(99) < done_pct);
    end
    res_ready = ($urandom_range(99) < rr_pct);
    @(negedge clock);
    e_start = m_active && (m_issued < m_n) && (m_iq.size() < IqDepth);
    e_cont  = m_active && (m_rq.size() < RqDepth);
    e_valid = (m_rq.size() > 0);
    chk("busy", busy, m_active);
    chk("finish", finish, m_finish);
    chk("err", err, m_err);
    chk("ap_start", ap_start, e_start);
    chk("ap_continue", ap_continue, e_cont);
    chk("res_valid", res_valid, e_valid);
    if (e_valid) begin
      chk("res_index", res_index, m_rq[0].idx);
      chk("res_latency", res_latency, m_rq[0].lat);
    end else begin
      chk("res_index_idle", res_index, 0);
      chk("res_latency_idle", res_latency, 0);
    end
    if (finish) fin_cnt++;
    if (ap_start && ap_ready) iss_cnt++;
    if (res_valid && res_ready) begin
      rx_idx.push_back(int'(res_index));
      rx_lat.push_back(res_latency);
    end
    // Kernel completes in issue order after a per-run delay.
    if (reset) k_due.delete();
    else if (!frc) begin
      if (ap_start && ap_ready) begin
        last = (k_due.size() > 0) ? k_due[k_due.size()-1] : 0;
        d = now + int'($urandom_range(dly_max, dly_min));
        k_due.push_back((d > last) ? d : last);
      end
      if (ap_done && ap_continue && k_due.size() > 0) void'(k_due.pop_front());
    end
    if (reset) model_clear();
    else begin
      rq_pre   = m_rq.size();
      ret_pre  = m_retired;
      act_pre  = m_active;
      idle_pre = !m_active && !m_finish;
      if (e_valid && res_ready) void'(m_rq.pop_front());
      if (e_start && ap_ready) begin
        m_iq.push_back(m_cyc);
        m_issued++;
      end
      if (ap_done && e_cont) begin
        if (m_iq.size() > 0) begin
          t = m_iq.pop_front();
          m_rq.push_back('{m_retired, m_cyc - t});
          m_retired++;
        end else m_err = 1;
      end
      exit_now = act_pre && (ret_pre == m_n) && (rq_pre == 0);
      m_finish = exit_now || (idle_pre && cfg_start && cfg_num == 0);
      if (act_pre) m_cyc++;
      if (exit_now) m_active = 0;
      if (idle_pre && cfg_start && cfg_num != 0) begin
        m_active = 1; m_n = int'(cfg_num);
        m_issued = 0; m_retired = 0; m_cyc = 0;
      end
    end
    @(posedge clock);
    #1;
    now++;
  endtask

  task automatic start_batch(input int n);
    cfg_start = 1'b1;
    cfg_num   = 16'(n);
    cycle();
    cfg_start = 1'b0;
  endtask

  task automatic wait_finish(input string tag, input int budget);
    int f0 = fin_cnt;
    int k  = 0;
    while (fin_cnt == f0 && k < budget) begin
      cycle();
      k++;
    end
    chk({tag, "_finish_in_budget"}, (fin_cnt != f0), 1);
  endtask

  task automatic set_env(input int rp, input int dp, input int rr, input int dmin, input int dmax);
    ready_pct = rp; done_pct = dp; rr_pct = rr; dly_min = dmin; dly_max = dmax;
  endtask

  initial begin
    int f0, i0, n;
    model_clear();
    frc = 0; f_ready = 0; f_done = 0;
    set_env(100, 100, 100, 10, 10);

    // Reset state.
    repeat (3) cycle();
    reset = 1'b0;
    cycle();

    // 1: fixed 10-cycle kernel, three runs.
    rx_idx.delete(); rx_lat.delete(); f0 = fin_cnt;
    start_batch(3);
    wait_finish("t1", 200);
    cycle();
    chk("t1_records", rx_idx.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rx_idx.size()) begin
        chk("t1_idx", rx_idx[i], i);
        chk("t1_lat", rx_lat[i], 10);
      end
    end
    chk("t1_finish_pulses", fin_cnt - f0, 1);
    chk("t1_err", err, 0);

    // 2: kernel silent for 20 cycles, issue limited by queue depth.
    set_env(100, 0, 100, 0, 0);
    rx_idx.delete(); rx_lat.delete();
    start_batch(6);
    i0 = iss_cnt;
    repeat (20) cycle();
    chk("t2_issues_in_flight", iss_cnt - i0, IqDepth);
    chk("t2_ap_start_blocked", ap_start, 0);
    done_pct = 100;
    wait_finish("t2", 300);
    chk("t2_records", rx_idx.size(), 6);

    // 3: consumer stalled, results back up into the kernel.
    set_env(100, 100, 0, 2, 2);
    rx_idx.delete(); rx_lat.delete(); f0 = fin_cnt;
    start_batch(5);
    repeat (30) cycle();
    chk("t3_no_records_yet", rx_idx.size(), 0);
    chk("t3_ap_continue_held", ap_continue, 0);
    chk("t3_res_valid", res_valid, 1);
    chk("t3_no_finish", fin_cnt - f0, 0);
    rr_pct = 100;
    wait_finish("t3", 200);
    chk("t3_records", rx_idx.size(), 5);
    for (int i = 0; i < 5; i++) if (i < rx_idx.size()) chk("t3_order", rx_idx[i], i);

    // 4: empty batch.
    rx_idx.delete(); rx_lat.delete(); f0 = fin_cnt; i0 = iss_cnt;
    start_batch(0);
    cycle();
    chk("t4_finish_now", fin_cnt - f0, 1);
    cycle();
    chk("t4_single_pulse", fin_cnt - f0, 1);
    chk("t4_no_issue", iss_cnt - i0, 0);
    chk("t4_no_records", rx_idx.size(), 0);

    // 5: spurious done before any issue, then a zero-latency run.
    set_env(100, 100, 100, 3, 3);
    rx_idx.delete(); rx_lat.delete();
    start_batch(2);
    frc = 1; f_ready = 0; f_done = 1;
    cycle();
    chk("t5_err_set", err, 1);
    f_ready = 1; f_done = 1;
    cycle();
    frc = 0;
    wait_finish("t5", 200);
    chk("t5_err_sticky", err, 1);
    chk("t5_records", rx_idx.size(), 2);
    if (rx_idx.size() == 2) begin
      chk("t5_idx0", rx_idx[0], 0);
      chk("t5_lat0", rx_lat[0], 0);
      chk("t5_idx1", rx_idx[1], 1);
    end

    // 6: asynchronous reset with two runs in flight, then a fresh batch.
    set_env(100, 100, 100, 20, 20);
    start_batch(4);
    repeat (2) cycle();
    chk("t6_ap_start_before", ap_start, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_ap_start_async", ap_start, 0);
    chk("t6_busy_async", busy, 0);
    chk("t6_err_async", err, 0);
    model_clear();
    k_due.delete();
    repeat (2) cycle();
    reset = 1'b0;
    set_env(100, 100, 100, 7, 7);
    rx_idx.delete(); rx_lat.delete();
    start_batch(1);
    wait_finish("t6", 100);
    chk("t6_records", rx_idx.size(), 1);
    if (rx_idx.size() == 1) begin
      chk("t6_idx", rx_idx[0], 0);
      chk("t6_lat", rx_lat[0], 7);
    end

    // Randomised batches, including stray cfg_start while busy.
    for (int b = 0; b < 8; b++) begin
      set_env(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
              int'($urandom_range(100, 20)), 0, int'($urandom_range(12, 0)));
      n = int'($urandom_range(12, 1));
      rx_idx.delete(); rx_lat.delete();
      start_batch(n);
      repeat (3) begin
        cfg_start = 1'b1;
        cfg_num   = 16'($urandom_range(9, 0));
        cycle();
      end
      cfg_start = 1'b0;
      wait_finish("rand", 3000);
      chk("rand_records", rx_idx.size(), n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
